// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, operand-B mux, 16-bit ALU, registered result/flags.
// Latency: 1 cycle from a valid input to out_valid and the registered outputs.
// Backpressure: none; every valid input is captured, so back-to-back inputs give back-to-back results.
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       opcode,
    input  logic [3:0]       func,
    input  logic             aluop,
    input  logic [WIDTH-1:0] read1,
    input  logic [WIDTH-1:0] read2,
    input  logic [6:0]       immediate,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             is_zero,
    output logic [2:0]       alu_code
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;
    localparam logic [2:0] OP_SLTI  = 3'b110;
    localparam logic [2:0] OP_ORI   = 3'b111;

    logic [2:0]       w_alu_code;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [3:0]       w_shamt;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_carry;
    logic             r_is_zero;
    logic [2:0]       r_alu_code;

    // ALU-control decode: opcode picks the operation; R-type defers to func.
    // aluop is deliberately not consulted here, it only steers operand B.
    always_comb begin
        w_alu_code = ALU_ADD;
        unique case (opcode)
            OP_RTYPE: begin
                case (func)
                    4'b0000: w_alu_code = ALU_ADD;
                    4'b0001: w_alu_code = ALU_SUB;
                    4'b0010: w_alu_code = ALU_AND;
                    4'b0011: w_alu_code = ALU_OR;
                    4'b0100: w_alu_code = ALU_XOR;
                    4'b0101: w_alu_code = ALU_SLT;
                    4'b0110: w_alu_code = ALU_SLL;
                    4'b0111: w_alu_code = ALU_SRL;
                    default: w_alu_code = ALU_ADD;
                endcase
            end
            OP_ADDI: w_alu_code = ALU_ADD;
            OP_LW:   w_alu_code = ALU_ADD;
            OP_SW:   w_alu_code = ALU_ADD;
            OP_BEQ:  w_alu_code = ALU_SUB;
            OP_J:    w_alu_code = ALU_ADD;
            OP_SLTI: w_alu_code = ALU_SLT;
            OP_ORI:  w_alu_code = ALU_OR;
            default: w_alu_code = ALU_ADD;
        endcase
    end

    // Operand B: sign-extended 7-bit immediate or the second register port.
    assign w_op_a  = read1;
    assign w_op_b  = aluop ? {{(WIDTH-7){immediate[6]}}, immediate} : read2;

    // Both adders are kept 17 bits wide so bit 16 is the carry / not-borrow.
    assign w_add   = {1'b0, w_op_a} + {1'b0, w_op_b};
    assign w_sub   = {1'b0, w_op_a} + {1'b0, ~w_op_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = w_op_b[3:0];

    // Result and carry selection; carry is only meaningful for ADD and SUB.
    always_comb begin
        w_result = w_add[WIDTH-1:0];
        w_carry  = 1'b0;
        unique case (w_alu_code)
            ALU_ADD: begin
                w_result = w_add[WIDTH-1:0];
                w_carry  = w_add[WIDTH];
            end
            ALU_SUB: begin
                w_result = w_sub[WIDTH-1:0];
                w_carry  = w_sub[WIDTH];
            end
            ALU_AND: w_result = w_op_a & w_op_b;
            ALU_OR:  w_result = w_op_a | w_op_b;
            ALU_XOR: w_result = w_op_a ^ w_op_b;
            ALU_SLT: w_result = ($signed(w_op_a) < $signed(w_op_b)) ?
                                {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            ALU_SLL: w_result = w_op_a << w_shamt;
            ALU_SRL: w_result = w_op_a >> w_shamt;
            default: w_result = w_add[WIDTH-1:0];
        endcase
    end

    // Output stage: capture only on valid so idle cycles leave the last result held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_out   <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_is_zero   <= 1'b0;
            r_alu_code  <= 3'b000;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alu_out  <= w_result;
                r_carry    <= w_carry;
                r_is_zero  <= (w_result == {WIDTH{1'b0}});
                r_alu_code <= w_alu_code;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign alu_out   = r_alu_out;
    assign carry     = r_carry;
    assign is_zero   = r_is_zero;
    assign alu_code  = r_alu_code;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, checked 1 time unit after each capture edge.
// Latency under test: 1 cycle; inputs change on the falling edge.
// No backpressure exists; consecutive valid steps exercise back-to-back issue.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  opcode;
    logic [3:0]  func;
    logic        aluop;
    logic [15:0] read1;
    logic [15:0] read2;
    logic [6:0]  immediate;
    logic        out_valid;
    logic [15:0] alu_out;
    logic        carry;
    logic        is_zero;
    logic [2:0]  alu_code;

    int tests = 0;
    int fails = 0;

    alu_exec_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .func      (func),
        .aluop     (aluop),
        .read1     (read1),
        .read2     (read2),
        .immediate (immediate),
        .out_valid (out_valid),
        .alu_out   (alu_out),
        .carry     (carry),
        .is_zero   (is_zero),
        .alu_code  (alu_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [15:0] o,
                           input logic c, input logic z, input logic [2:0] code);
        chk({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
        chk({tag, ".out"},   alu_out, o);
        chk({tag, ".carry"}, {15'd0, carry}, {15'd0, c});
        chk({tag, ".zero"},  {15'd0, is_zero}, {15'd0, z});
        chk({tag, ".code"},  {13'd0, alu_code}, {13'd0, code});
    endtask

    // Drive one cycle's inputs on the falling edge, then wait past the capture edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [3:0] fn,
                        input logic ao, input logic [15:0] r1, input logic [15:0] r2,
                        input logic [6:0] imm);
        @(negedge clk);
        in_valid  = v;
        opcode    = op;
        func      = fn;
        aluop     = ao;
        read1     = r1;
        read2     = r2;
        immediate = imm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = 3'd0; func = 4'd0; aluop = 1'b0;
        read1 = 16'd0; read2 = 16'd0; immediate = 7'd0;
        #2;
        chk_all("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type ADD overflow
        step(1, 3'b000, 4'b0000, 0, 16'hFFFF, 16'h0001, 7'h00);
        chk_all("add_ovf", 1'b1, 16'h0000, 1'b1, 1'b1, 3'b000);
        // ADDI with -1 immediate
        step(1, 3'b001, 4'b0000, 1, 16'h0005, 16'h0000, 7'h7F);
        chk_all("addi_neg", 1'b1, 16'h0004, 1'b1, 1'b0, 3'b000);
        // BEQ equal and unequal
        step(1, 3'b100, 4'b0000, 0, 16'h1234, 16'h1234, 7'h00);
        chk_all("beq_eq", 1'b1, 16'h0000, 1'b1, 1'b1, 3'b001);
        step(1, 3'b100, 4'b0000, 0, 16'h1234, 16'h1235, 7'h00);
        chk_all("beq_ne", 1'b1, 16'hFFFF, 1'b0, 1'b0, 3'b001);
        // Signed SLT both orders
        step(1, 3'b000, 4'b0101, 0, 16'h8000, 16'h0001, 7'h00);
        chk_all("slt_neg", 1'b1, 16'h0001, 1'b0, 1'b0, 3'b101);
        step(1, 3'b000, 4'b0101, 0, 16'h0001, 16'h8000, 7'h00);
        chk_all("slt_swap", 1'b1, 16'h0000, 1'b0, 1'b1, 3'b101);
        // Shifts use only B[3:0]
        step(1, 3'b000, 4'b0110, 0, 16'h0001, 16'h0013, 7'h00);
        chk_all("sll", 1'b1, 16'h0008, 1'b0, 1'b0, 3'b110);
        step(1, 3'b000, 4'b0111, 0, 16'h8000, 16'h000F, 7'h00);
        chk_all("srl", 1'b1, 16'h0001, 1'b0, 1'b0, 3'b111);
        // Logic ops
        step(1, 3'b000, 4'b0010, 0, 16'hF0F0, 16'h3C3C, 7'h00);
        chk_all("and", 1'b1, 16'h3030, 1'b0, 1'b0, 3'b010);
        step(1, 3'b000, 4'b0011, 0, 16'hF000, 16'h000F, 7'h00);
        chk_all("or", 1'b1, 16'hF00F, 1'b0, 1'b0, 3'b011);
        step(1, 3'b000, 4'b0100, 0, 16'hFFFF, 16'h00FF, 7'h00);
        chk_all("xor", 1'b1, 16'hFF00, 1'b0, 1'b0, 3'b100);
        // Unused func falls back to ADD
        step(1, 3'b000, 4'b1000, 0, 16'h0003, 16'h0004, 7'h00);
        chk_all("func_dflt", 1'b1, 16'h0007, 1'b0, 1'b0, 3'b000);
        // R-type with immediate operand: decode ignores aluop
        step(1, 3'b000, 4'b0001, 1, 16'h0005, 16'hAAAA, 7'h02);
        chk_all("rsub_imm", 1'b1, 16'h0003, 1'b1, 1'b0, 3'b001);
        // LW / SW / J address adds
        step(1, 3'b010, 4'b0000, 1, 16'h1000, 16'h0000, 7'h3F);
        chk_all("lw", 1'b1, 16'h103F, 1'b0, 1'b0, 3'b000);
        step(1, 3'b011, 4'b0000, 1, 16'h0100, 16'h0000, 7'h40);
        chk_all("sw", 1'b1, 16'h00C0, 1'b1, 1'b0, 3'b000);
        step(1, 3'b101, 4'b0111, 0, 16'h0010, 16'h0020, 7'h00);
        chk_all("j", 1'b1, 16'h0030, 1'b0, 1'b0, 3'b000);
        // SLTI: -1 < +1 ; ORI with sign-extended positive immediate
        step(1, 3'b110, 4'b0000, 1, 16'hFFFF, 16'h0000, 7'h01);
        chk_all("slti", 1'b1, 16'h0001, 1'b0, 1'b0, 3'b101);
        step(1, 3'b111, 4'b0000, 1, 16'h0F00, 16'h0000, 7'h30);
        chk_all("ori", 1'b1, 16'h0F30, 1'b0, 1'b0, 3'b011);

        // Hold: result 0x0004 then idle cycles with changing operands
        step(1, 3'b001, 4'b0000, 1, 16'h0005, 16'h0000, 7'h7F);
        chk_all("hold_pre", 1'b1, 16'h0004, 1'b1, 1'b0, 3'b000);
        step(0, 3'b100, 4'b0101, 0, 16'hDEAD, 16'hBEEF, 7'h11);
        chk_all("hold1", 1'b0, 16'h0004, 1'b1, 1'b0, 3'b000);
        step(0, 3'b110, 4'b0111, 1, 16'h1234, 16'h5678, 7'h40);
        chk_all("hold2", 1'b0, 16'h0004, 1'b1, 1'b0, 3'b000);

        // Asynchronous reset between edges
        step(1, 3'b000, 4'b0011, 0, 16'h00F0, 16'h0F00, 7'h00);
        chk_all("pre_rst", 1'b1, 16'h0FF0, 1'b0, 1'b0, 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 3'b000);
        // Reset dominates a valid input at the edge
        step(1, 3'b000, 4'b0000, 0, 16'h0001, 16'h0001, 7'h00);
        chk_all("rst_prio", 1'b0, 16'h0000, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3'b000, 4'b0000, 0, 16'h0001, 16'h0001, 7'h00);
        chk_all("post_rst", 1'b1, 16'h0002, 1'b0, 1'b0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage of the 16-bit CPU: the ALU-control decode, the second-operand mux (register vs. immediate) and the 16-bit ALU, combined into one block with a registered output stage.
- Inputs come from instruction decode and the register file.
- The registered result, carry and zero flag feed memory addressing, writeback and branch logic.

Parameters:
- WIDTH, 16, datapath width (fixed at 16; the immediate width of 7 is not parameterised)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and control are valid this cycle
- opcode  input  3  instruction[15:13]
- func  input  4  instruction[3:0], R-type function
- aluop  input  1  operand-B select from main control: 1 = immediate, 0 = read2
- read1  input  16  register-file port A (rs), ALU operand A
- read2  input  16  register-file port B (rt)
- immediate  input  7  instruction[6:0]
- out_valid  output  1  registered result valid
- alu_out  output  16  registered ALU result
- carry  output  1  registered carry flag
- is_zero  output  1  registered zero flag
- alu_code  output  3  registered decoded ALU operation, for debug and branch logic

Behaviour:
- One clock; reset is asynchronous and active-low.
  - rst_n low forces out_valid=0, alu_out=0, carry=0, is_zero=0, alu_code=000 immediately, independent of clk.
  - Outputs stay at these values until the first valid capture after release.
- Operand B is selected combinationally.
  - aluop=1: B = immediate sign-extended to 16 bits (bit 6 replicated).
  - aluop=0: B = read2.
- ALU codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- ALU control decode, from opcode:
  - 000 R-type, code selected by func: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL. Any other func gives ADD.
  - 001 ADDI = ADD; 010 LW = ADD; 011 SW = ADD; 100 BEQ = SUB; 101 J = ADD (result unused); 110 SLTI = SLT; 111 ORI = OR.
  - The decode uses opcode only; aluop is not consulted, and operand selection comes solely from aluop.
- Arithmetic:
  - ADD: 17-bit A+B; alu_out = low 16 bits; carry = bit 16.
  - SUB: computed as A + ~B + 1; alu_out = low 16 bits; carry = bit 16 (1 means no borrow, i.e. A >= B unsigned).
  - SLT: alu_out = 0x0001 if A < B as signed two's-complement, else 0x0000.
  - SLL / SRL: A shifted logically by B[3:0]; B[15:4] ignored; zero fill.
  - carry = 0 for every operation except ADD and SUB.
  - is_zero = 1 iff the 16-bit result is 0x0000, for every operation.
- Latency: 1 cycle.
  - On a rising clk edge with in_valid=1, capture result, flags and alu_code, and set out_valid=1.
  - On a rising edge with in_valid=0, set out_valid=0; alu_out, carry, is_zero and alu_code hold their previous values.
- Back-to-back valid inputs produce back-to-back valid outputs. There is no backpressure.
- Reset takes priority over a simultaneous clock edge.
- Inputs carrying X while in_valid=0 must not disturb the held outputs.

Test Plan:
- R-type ADD overflow.
  - Stimulus: opcode=000, func=0000, aluop=0, read1=0xFFFF, read2=0x0001, in_valid=1.
  - Next edge: alu_out=0x0000, carry=1, is_zero=1, alu_code=000, out_valid=1.
- ADDI with negative immediate.
  - Stimulus: opcode=001, aluop=1, immediate=7'h7F, read1=0x0005.
  - Response: alu_out=0x0004, carry=1, is_zero=0.
- BEQ compare.
  - Stimulus: opcode=100, aluop=0, read1=read2=0x1234. Response: alu_out=0x0000, is_zero=1, carry=1.
  - Repeat with read2=0x1235. Response: alu_out=0xFFFF, is_zero=0, carry=0.
- Signed SLT.
  - Stimulus: opcode=000, func=0101, read1=0x8000, read2=0x0001. Response: alu_out=0x0001.
  - Swap operands. Response: alu_out=0x0000.
- Shifts.
  - SLL (func=0110), read1=0x0001, read2=0x0013: alu_out=0x0008 (only B[3:0]=3 used).
  - SRL (func=0111), read1=0x8000, read2=0x000F: alu_out=0x0001.
- Reset and hold.
  - Hold: after a valid result of 0x0004, drive in_valid=0 with changing operands; out_valid=0 and alu_out stays 0x0004.
  - Reset: assert rst_n=0 between clock edges; all outputs read 0 before the next edge.
